div_ctrl_hilo: RTL and testbench

Multiply/divide-side controller for the 54-instruction CPU. It sits between the EX stage and the 32-cycle unsigned restoring divider, and owns the architectural HI/LO registers. For DIV/DIVU it converts operands to magnitudes, issues a one-cycle start to the divider and stalls the pipeline until the result is ready. It then sign-corrects the quotient and remainder and writes HI/LO; it also services MTHI/MTLO.

---
 rtl/div_ctrl_hilo_pkg.sv | 23 ++
 rtl/div_ctrl_hilo_if.sv | 23 ++
 rtl/div_ctrl_hilo_sign_fix.sv | 17 +
 rtl/div_ctrl_hilo.sv | 154 +++++++++++++++
 tb/tb_div_ctrl_hilo.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/div_ctrl_hilo_pkg.sv
// Shared types, constants and arithmetic helpers for the HI/LO divide controller.
package hilo_pkg;

  localparam int WIDTH = 32;
  localparam logic [WIDTH-1:0] DIV0_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    WB
  } state_t;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  // 32'h8000_0000 maps onto itself, which is the correct unsigned magnitude.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? negate(x) : x;
  endfunction

endpackage

// File: rtl/div_ctrl_hilo_if.sv
// Handshake and data bus between the HI/LO controller (master) and the external divider (slave).
interface div_ctrl_hilo_if #(
  parameter int WIDTH = 32
);

  logic             div_start;
  logic [WIDTH-1:0] div_dividend;
  logic [WIDTH-1:0] div_divisor;
  logic             div_busy;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] div_r;

  modport master (
    output div_start, div_dividend, div_divisor,
    input  div_busy, div_q, div_r
  );

  modport slave (
    input  div_start, div_dividend, div_divisor,
    output div_busy, div_q, div_r
  );

endinterface

// File: rtl/div_ctrl_hilo_sign_fix.sv
// Conditional two's-complement negation of an operand pair: operand magnitudes
// before issue, and quotient/remainder sign correction at writeback.
module div_sign_fix
  import hilo_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             neg_a,
  input  logic             neg_b,
  output logic [WIDTH-1:0] fix_a,
  output logic [WIDTH-1:0] fix_b
);

  assign fix_a = neg_a ? negate(a) : a;
  assign fix_b = neg_b ? negate(b) : b;

endmodule

// File: rtl/div_ctrl_hilo.sv
// DIV/DIVU sequencing against an external divider, plus HI/LO and MTHI/MTLO.
// Define HILO_FWD_EN to forward the value being written onto hi/lo in the same cycle.
module div_ctrl_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             op_div,
  input  logic             op_divu,
  input  logic             op_mthi,
  input  logic             op_mtlo,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  div_ctrl_hilo_if.master  dvd
);

  import hilo_pkg::*;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] dividend_q;
  logic [WIDTH-1:0] divisor_q;
  logic             sgn_q;
  logic             sgn_r;
  logic             seen_busy;

  logic             div_req;
  logic             is_signed;
  logic             rt_zero;
  logic             by_zero;
  logic [WIDTH-1:0] rs_mag;
  logic [WIDTH-1:0] rt_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH-1:0] r_src;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] hi_nxt;
  logic [WIDTH-1:0] lo_nxt;

  assign div_req   = op_div | op_divu;
  assign is_signed = op_div;
  assign rt_zero   = (rt_data == '0);

  // A latched zero divisor marks the divide-by-zero path; a nonzero divisor never has a zero magnitude.
  assign by_zero = (divisor_q == '0);
  assign r_src   = by_zero ? dividend_q : dvd.div_r;

  div_sign_fix u_pre (
    .a     (rs_data),
    .b     (rt_data),
    .neg_a (is_signed & rs_data[WIDTH-1]),
    .neg_b (is_signed & rt_data[WIDTH-1]),
    .fix_a (rs_mag),
    .fix_b (rt_mag)
  );

  div_sign_fix u_wb (
    .a     (dvd.div_q),
    .b     (r_src),
    .neg_a (sgn_q),
    .neg_b (sgn_r),
    .fix_a (q_fix),
    .fix_b (r_fix)
  );

  assign dvd.div_start    = (state == ISSUE);
  assign dvd.div_dividend = dividend_q;
  assign dvd.div_divisor  = divisor_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b1;
    hi_we     = 1'b0;
    lo_we     = 1'b0;
    hi_nxt    = hi_q;
    lo_nxt    = lo_q;
    case (state)
      IDLE: begin
        stall = div_req;
        if (div_req) begin
          state_nxt = rt_zero ? WB : ISSUE;
        end else begin
          if (op_mthi) begin
            hi_we  = 1'b1;
            hi_nxt = rs_data;
          end
          if (op_mtlo) begin
            lo_we  = 1'b1;
            lo_nxt = rs_data;
          end
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (!dvd.div_busy && seen_busy) state_nxt = WB;
      end
      WB: begin
        hi_we     = 1'b1;
        lo_we     = 1'b1;
        hi_nxt    = r_fix;
        lo_nxt    = by_zero ? DIV0_LO : q_fix;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hi_q       <= '0;
      lo_q       <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      sgn_q      <= 1'b0;
      sgn_r      <= 1'b0;
      seen_busy  <= 1'b0;
    end else begin
      if (hi_we) hi_q <= hi_nxt;
      if (lo_we) lo_q <= lo_nxt;
      if (state == IDLE && div_req) begin
        dividend_q <= rs_mag;
        divisor_q  <= rt_mag;
        sgn_q      <= is_signed & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
        sgn_r      <= is_signed & rs_data[WIDTH-1];
      end
      if (state == ISSUE)                     seen_busy <= 1'b0;
      else if (state == WAIT && dvd.div_busy) seen_busy <= 1'b1;
    end
  end

`ifdef HILO_FWD_EN
  assign hi = hi_we ? hi_nxt : hi_q;
  assign lo = lo_we ? lo_nxt : lo_q;
`else
  assign hi = hi_q;
  assign lo = lo_q;
`endif

  // The decoder should never pair a divide with MTHI/MTLO; the move is silently dropped.
  mt_div_collision: assert property (@(posedge clock) disable iff (reset)
    !(state == IDLE && div_req && (op_mthi || op_mtlo)));

endmodule

// File: tb/tb_div_ctrl_hilo.sv
// Self-checking bench for div_ctrl_hilo with a behavioural 32-cycle divider and a HI/LO reference model.
module tb_div_ctrl_hilo;

  logic        clock;
  logic        reset;
  logic        op_div;
  logic        op_divu;
  logic        op_mthi;
  logic        op_mtlo;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int          checks;
  int          errors;
  logic [31:0] model_hi;
  logic [31:0] model_lo;

  logic        m_busy;
  logic [4:0]  m_cnt;
  logic [31:0] m_q;
  logic [31:0] m_r;

  div_ctrl_hilo_if #(.WIDTH(32)) dvd ();

  assign dvd.div_busy = m_busy;
  assign dvd.div_q    = m_q;
  assign dvd.div_r    = m_r;

  div_ctrl_hilo #(.WIDTH(32)) dut (
    .clock   (clock),
    .reset   (reset),
    .op_div  (op_div),
    .op_divu (op_divu),
    .op_mthi (op_mthi),
    .op_mtlo (op_mtlo),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .stall   (stall),
    .hi      (hi),
    .lo      (lo),
    .dvd     (dvd)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Divider: busy from the cycle after start for 32 cycles, results held afterwards.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_busy <= 1'b0;
      m_cnt  <= '0;
      m_q    <= '0;
      m_r    <= '0;
    end else if (dvd.div_start) begin
      m_busy <= 1'b1;
      m_cnt  <= 5'd31;
      m_q    <= (dvd.div_divisor != 0) ? dvd.div_dividend / dvd.div_divisor : 32'hFFFF_FFFF;
      m_r    <= (dvd.div_divisor != 0) ? dvd.div_dividend % dvd.div_divisor : dvd.div_dividend;
    end else if (m_busy) begin
      if (m_cnt == 0) m_busy <= 1'b0;
      else            m_cnt  <= m_cnt - 5'd1;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  function automatic void refDiv(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] exp_lo, output logic [31:0] exp_hi);
    longint x;
    longint y;
    if (b == 0) begin
      exp_lo = 32'hFFFF_FFFF;
      exp_hi = a;
      return;
    end
    if (sgn) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = longint'({32'b0, a});
      y = longint'({32'b0, b});
    end
    exp_lo = 32'(x / y);
    exp_hi = 32'(x % y);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit div, input bit divu, input bit mthi, input bit mtlo,
                               input logic [31:0] rs, input logic [31:0] rt);
    @(negedge clock);
    op_div  = div;
    op_divu = divu;
    op_mthi = mthi;
    op_mtlo = mtlo;
    rs_data = rs;
    rt_data = rt;
    #1;
  endtask

  task automatic runDivide(input bit sgn, input logic [31:0] rs, input logic [31:0] rt, input string tag);
    logic [31:0] exp_lo;
    logic [31:0] exp_hi;
    logic [31:0] exp_mag;
    int          cycles;
    int          starts;
    refDiv(sgn, rs, rt, exp_lo, exp_hi);
    exp_mag = (sgn && rs[31]) ? (~rs + 32'd1) : rs;
    applyStimulus(sgn, !sgn, 1'b0, 1'b0, rs, rt);
    checkOutput({tag, "_stall_accept"}, 32'(stall), 32'd1);
    @(posedge clock);
    #1;
    op_div  = 1'b0;
    op_divu = 1'b0;
    cycles  = 1;
    starts  = 0;
    if (rt != 0) checkOutput({tag, "_dividend_mag"}, dvd.div_dividend, exp_mag);
    while (stall === 1'b1 && cycles < 200) begin
      if (dvd.div_start === 1'b1) starts++;
      cycles++;
      @(posedge clock);
      #1;
    end
    checkOutput({tag, "_stall_cycles"}, 32'(cycles), (rt == 0) ? 32'd2 : 32'd36);
    checkOutput({tag, "_starts"}, 32'(starts), (rt == 0) ? 32'd0 : 32'd1);
    checkOutput({tag, "_lo"}, lo, exp_lo);
    checkOutput({tag, "_hi"}, hi, exp_hi);
    model_lo = exp_lo;
    model_hi = exp_hi;
  endtask

  task automatic runMove(input bit to_hi, input logic [31:0] val, input string tag);
    applyStimulus(1'b0, 1'b0, to_hi, !to_hi, val, 32'd0);
    checkOutput({tag, "_stall"}, 32'(stall), 32'd0);
`ifdef HILO_FWD_EN
    checkOutput({tag, "_same_cycle"}, to_hi ? hi : lo, val);
`else
    checkOutput({tag, "_same_cycle"}, to_hi ? hi : lo, to_hi ? model_hi : model_lo);
`endif
    if (to_hi) model_hi = val;
    else       model_lo = val;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput({tag, "_hi"}, hi, model_hi);
    checkOutput({tag, "_lo"}, lo, model_lo);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    bit          sgn;
    checks   = 0;
    errors   = 0;
    model_hi = '0;
    model_lo = '0;
    reset    = 1'b1;
    op_div   = 1'b0;
    op_divu  = 1'b0;
    op_mthi  = 1'b0;
    op_mtlo  = 1'b0;
    rs_data  = '0;
    rt_data  = '0;
    #12;
    checkOutput("reset_hi", hi, 32'd0);
    checkOutput("reset_lo", lo, 32'd0);
    checkOutput("reset_stall", 32'(stall), 32'd0);
    checkOutput("reset_start", 32'(dvd.div_start), 32'd0);
    checkOutput("reset_dividend", dvd.div_dividend, 32'd0);
    checkOutput("reset_divisor", dvd.div_divisor, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    runDivide(1'b0, 32'd100, 32'd7, "divu_100_7");
    runDivide(1'b1, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    runDivide(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
    runDivide(1'b0, 32'd5, 32'd0, "divu_by_zero");
    runDivide(1'b1, 32'hFFFF_FFF0, 32'd0, "div_neg_by_zero");

    // MTHI then MTLO on back-to-back cycles.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'd0);
    checkOutput("mthi_stall", 32'(stall), 32'd0);
`ifdef HILO_FWD_EN
    checkOutput("mthi_same_cycle", hi, 32'hDEAD_BEEF);
`else
    checkOutput("mthi_same_cycle", hi, model_hi);
`endif
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1234, 32'd0);
    checkOutput("mtlo_stall", 32'(stall), 32'd0);
    checkOutput("mthi_next", hi, 32'hDEAD_BEEF);
`ifdef HILO_FWD_EN
    checkOutput("mtlo_same_cycle", lo, 32'h0000_1234);
`else
    checkOutput("mtlo_same_cycle", lo, model_lo);
`endif
    model_hi = 32'hDEAD_BEEF;
    model_lo = 32'h0000_1234;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    checkOutput("mtlo_next", lo, 32'h0000_1234);
    checkOutput("mt_hi_kept", hi, 32'hDEAD_BEEF);

    // Reset lands partway through the divider's busy window.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd1000, 32'd3);
    @(posedge clock);
    #1;
    op_divu = 1'b0;
    repeat (10) @(posedge clock);
    #2;
    checkOutput("mid_busy_stall", 32'(stall), 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("async_reset_stall", 32'(stall), 32'd0);
    checkOutput("async_reset_hi", hi, 32'd0);
    checkOutput("async_reset_lo", lo, 32'd0);
    checkOutput("async_reset_start", 32'(dvd.div_start), 32'd0);
    model_hi = '0;
    model_lo = '0;
    @(negedge clock);
    reset = 1'b0;
    runDivide(1'b0, 32'd9, 32'd3, "divu_9_3_after_reset");

    for (int i = 0; i < 14; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        runMove($urandom_range(0, 1) == 1, $urandom, $sformatf("rnd%0d_mt", i));
      end else begin
        sgn = ($urandom_range(0, 1) == 1);
        a   = $urandom;
        case ($urandom_range(0, 4))
          0:       b = 32'd0;
          1:       b = 32'($urandom_range(1, 15));
          2:       b = ~32'($urandom_range(0, 14));
          default: b = $urandom;
        endcase
        if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
        runDivide(sgn, a, b, $sformatf("rnd%0d_%s", i, sgn ? "div" : "divu"));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
